if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined CPU: owns the program counter and drives the address side of the combinational instruction memory. It captures the returned word into the IF/ID pipeline register. It handles hazard-unit stalls, branch/jump redirects from EX, and flushes, and reports misaligned redirect targets and a retired-fetch count.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: bubble instruction placed in IF/ID (addi x0,x0,0).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall_i`  in  1  hazard unit: hold PC and IF/ID.
- `flush_i`  in  1  squash IF/ID contents (insert bubble).
- `redirect_valid_i`  in  1  EX-stage taken branch/jump this cycle.
- `redirect_pc_i`  in  32  redirect target byte address.
- `imem_addr_o`  out  32  byte address to instruction memory (= current PC).
- `imem_instr_i`  in  32  instruction word returned combinationally for `imem_addr_o`.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction.
- `ifid_pc_o`  out  32  PC of instruction in IF/ID.
- `ifid_pc4_o`  out  32  PC+4 of instruction in IF/ID.
- `ifid_instr_o`  out  32  instruction in IF/ID.
- `misalign_o`  out  1  one-cycle pulse: last accepted redirect target had bits[1:0] ≠ 0.
- `fetch_count_o`  out  32  number of valid instructions latched into IF/ID since reset.

## Operation
- `imem_addr_o` is the PC register driven directly; no gating, no extra logic in the path.
- Per-edge priority: `rst` > `redirect_valid_i` > `flush_i` > `stall_i` > normal advance.
- Reset: PC ← `RESET_PC`; `ifid_valid_o` 0, `ifid_instr_o` `NOP_INSTR`, `ifid_pc_o`/`ifid_pc4_o` 0, `misalign_o` 0, `fetch_count_o` 0.
- Redirect: PC ← {`redirect_pc_i`[31:2], 2'b00}; IF/ID ← bubble (valid 0, `NOP_INSTR`, pc/pc4 0). `misalign_o` ← |`redirect_pc_i`[1:0]. The redirect overrides a simultaneous `stall_i`, and the word fetched this cycle is discarded.
- Flush without redirect: IF/ID ← bubble. PC advances by 4 if `stall_i`=0 and holds if `stall_i`=1.
- Stall without flush/redirect: PC and all IF/ID fields hold their values; `fetch_count_o` holds.
- Normal advance: IF/ID ← {1, PC, PC+4, `imem_instr_i`}; PC ← PC+4.
- PC+4 is 32-bit modulo: 32'hFFFF_FFFC advances to 32'h0000_0000. Word-index wrap inside instruction memory is outside this block.
- `fetch_count_o` increments by 1 exactly on edges where IF/ID loads valid=1, and wraps modulo 2^32.
- `misalign_o` is 0 on every edge that is not a redirect edge.
- The bubble content is fixed; a valid instruction whose word equals `NOP_INSTR` still has valid=1 and is counted.

## Timing
- Fetch latency: the address is presented in cycle N and the instruction is visible on IF/ID outputs in cycle N+1.
- First edge with `rst`=0 latches {1, `RESET_PC`, `RESET_PC`+4, mem[`RESET_PC`]}.
- Redirect asserted in cycle N: `imem_addr_o` equals the target in N+1, IF/ID shows a bubble in N+1, and the target instruction is valid in IF/ID in N+2. The penalty is one bubble from this block.
- Stall asserted for k cycles: PC and IF/ID are frozen for k edges, and the stream resumes with no lost or duplicated instruction.
- `rst` asserted mid-stream, including during stall or redirect: full reset state on that edge, and any pending redirect is dropped.
- All outputs are registered except `imem_addr_o`, which is also a register output.

## Test plan
- Reset release, memory holds word i = 32'h1000_0000+i: IF/ID shows pc 0x0,0x4,0x8 with instr 0x1000_0000,…_0001,…_0002 on successive cycles; `fetch_count_o` = 3 after the third.
- `stall_i` high for 3 cycles while IF/ID holds pc 0x8: pc 0x8 is held for 3 extra cycles, then pc 0xC follows, and `fetch_count_o` does not increment during the stall.
- `redirect_valid_i`=1 with target 0x40 while `stall_i`=1: next cycle has `imem_addr_o`=0x40 and IF/ID valid=0 with instr 0x0000_0013; the following cycle has IF/ID pc 0x40 valid.
- Redirect target 0x43: PC becomes 0x40, `misalign_o`=1 for exactly one cycle, and it returns to 0.
- `flush_i` alone at PC 0x10: IF/ID shows a bubble and PC advances to 0x14; the same with `stall_i`=1 gives a bubble with PC held at 0x10.
- `RESET_PC`=32'hFFFF_FFFC: first valid pc is 0xFFFF_FFFC with pc4 0x0, and the next fetch address is 0x0. Asserting `rst` afterward returns all outputs to reset values on that edge.

Source files
------------

// File: rtl/if_stage_if.sv
// Bus between the instruction-fetch stage and the rest of the pipeline: hazard and
// redirect controls, the instruction-memory address/data pair, and the IF/ID register.
interface if_stage_if;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_instr_o;
  logic        misalign_o;
  logic [31:0] fetch_count_o;

  // Pipeline and memory side: drives the controls and the fetched word.
  modport master (
    output stall_i, flush_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
    input  imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
           misalign_o, fetch_count_o
  );

  // Fetch stage side.
  modport slave (
    input  stall_i, flush_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
    output imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
           misalign_o, fetch_count_o
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, presents it to combinational instruction
// memory and captures the returned word into IF/ID. Handles stall, flush and redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.slave  bus
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic [XLEN-1:0] ifid_pc_q;
  logic [XLEN-1:0] ifid_pc4_q;
  logic [XLEN-1:0] ifid_instr_q;
  logic            misalign_q;
  logic [XLEN-1:0] count_q;
  logic [XLEN-1:0] pc_plus4_c;

  assign pc_plus4_c = XLEN'(pc_q + XLEN'(4));

  // Priority per edge: reset, redirect, flush, stall, then normal advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= NOP_INSTR;
      misalign_q   <= 1'b0;
      count_q      <= '0;
    end else if (bus.redirect_valid_i) begin
      // Target is forced to a word boundary; the low bits only raise the flag.
      pc_q         <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
      valid_q      <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= NOP_INSTR;
      misalign_q   <= |bus.redirect_pc_i[1:0];
    end else if (bus.flush_i) begin
      valid_q      <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= NOP_INSTR;
      misalign_q   <= 1'b0;
      if (!bus.stall_i) begin
        pc_q <= pc_plus4_c;
      end
    end else if (bus.stall_i) begin
      misalign_q <= 1'b0;
    end else begin
      pc_q         <= pc_plus4_c;
      valid_q      <= 1'b1;
      ifid_pc_q    <= pc_q;
      ifid_pc4_q   <= pc_plus4_c;
      ifid_instr_q <= bus.imem_instr_i;
      misalign_q   <= 1'b0;
      count_q      <= XLEN'(count_q + XLEN'(1));
    end
  end

  assign bus.imem_addr_o   = pc_q;
  assign bus.ifid_valid_o  = valid_q;
  assign bus.ifid_pc_o     = ifid_pc_q;
  assign bus.ifid_pc4_o    = ifid_pc4_q;
  assign bus.ifid_instr_o  = ifid_instr_q;
  assign bus.misalign_o    = misalign_q;
  assign bus.fetch_count_o = count_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory word at byte address a is 32'h1000_0000 + a/4.
// A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
module tb_if_stage;
  logic clk;
  logic rst;
  logic rst2;
  int   checks;
  int   failures;

  if_stage_if bus ();
  if_stage_if bus2 ();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.slave)
  );

  assign bus.imem_instr_i  = 32'h1000_0000 + (bus.imem_addr_o >> 2);
  assign bus2.imem_instr_i = 32'h1000_0000 + (bus2.imem_addr_o >> 2);

  // Snapshot order: {valid, misalign, addr, pc, pc4, instr, count}.
  logic [161:0] obs;
  logic [161:0] obs2;
  logic [161:0] exp;
  assign obs  = {bus.ifid_valid_o, bus.misalign_o, bus.imem_addr_o, bus.ifid_pc_o,
                 bus.ifid_pc4_o, bus.ifid_instr_o, bus.fetch_count_o};
  assign obs2 = {bus2.ifid_valid_o, bus2.misalign_o, bus2.imem_addr_o, bus2.ifid_pc_o,
                 bus2.ifid_pc4_o, bus2.ifid_instr_o, bus2.fetch_count_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_0013, 32'd0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset got=%h exp=%h", obs, exp); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    step();
    exp = {1'b1, 1'b0, 32'h4, 32'h0, 32'h4, 32'h1000_0000, 32'd1};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL stream0 got=%h exp=%h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h8, 32'h4, 32'h8, 32'h1000_0001, 32'd2};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL stream1 got=%h exp=%h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'hC, 32'h8, 32'hC, 32'h1000_0002, 32'd3};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL stream2 got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_stall();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = {1'b1, 1'b0, 32'hC, 32'h8, 32'hC, 32'h1000_0002, 32'd3};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL stall%0d got=%h exp=%h", i, obs, exp); end
    end
    bus.stall_i = 1'b0;
    step();
    exp = {1'b1, 1'b0, 32'h10, 32'hC, 32'h10, 32'h1000_0003, 32'd4};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL stall_resume got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_flush();
    bus.flush_i = 1'b1;
    bus.stall_i = 1'b1;
    step();
    exp = {1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0000_0013, 32'd4};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL flush_stall got=%h exp=%h", obs, exp); end
    bus.stall_i = 1'b0;
    step();
    exp = {1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 32'h0000_0013, 32'd4};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL flush_adv got=%h exp=%h", obs, exp); end
    bus.flush_i = 1'b0;
    step();
    exp = {1'b1, 1'b0, 32'h18, 32'h14, 32'h18, 32'h1000_0005, 32'd5};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL flush_resume got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_redirect_stall();
    bus.stall_i          = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h40;
    step();
    exp = {1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0000_0013, 32'd5};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL redir_bubble got=%h exp=%h", obs, exp); end
    bus.stall_i          = 1'b0;
    bus.redirect_valid_i = 1'b0;
    step();
    exp = {1'b1, 1'b0, 32'h44, 32'h40, 32'h44, 32'h1000_0010, 32'd6};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL redir_target got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_misalign();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h43;
    step();
    exp = {1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 32'h0000_0013, 32'd6};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL misalign_set got=%h exp=%h", obs, exp); end
    bus.redirect_valid_i = 1'b0;
    step();
    exp = {1'b1, 1'b0, 32'h44, 32'h40, 32'h44, 32'h1000_0010, 32'd7};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL misalign_clr got=%h exp=%h", obs, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h48, 32'h44, 32'h48, 32'h1000_0011, 32'd8};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL misalign_next got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_reset_mid();
    rst                  = 1'b1;
    bus.stall_i          = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h83;
    step();
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_0013, 32'd0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_mid got=%h exp=%h", obs, exp); end
    rst                  = 1'b0;
    bus.stall_i          = 1'b0;
    bus.redirect_valid_i = 1'b0;
    step();
    exp = {1'b1, 1'b0, 32'h4, 32'h0, 32'h4, 32'h1000_0000, 32'd1};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_mid_resume got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_wrap();
    exp = {1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0000_0013, 32'd0};
    checks++;
    if (obs2 !== exp) begin failures++; $display("FAIL wrap_reset got=%h exp=%h", obs2, exp); end
    rst2 = 1'b0;
    step();
    exp = {1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4FFF_FFFF, 32'd1};
    checks++;
    if (obs2 !== exp) begin failures++; $display("FAIL wrap_first got=%h exp=%h", obs2, exp); end
    step();
    exp = {1'b1, 1'b0, 32'h4, 32'h0, 32'h4, 32'h1000_0000, 32'd2};
    checks++;
    if (obs2 !== exp) begin failures++; $display("FAIL wrap_second got=%h exp=%h", obs2, exp); end
    rst2 = 1'b1;
    step();
    exp = {1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0000_0013, 32'd0};
    checks++;
    if (obs2 !== exp) begin failures++; $display("FAIL wrap_rerst got=%h exp=%h", obs2, exp); end
  endtask

  initial begin
    checks                = 0;
    failures              = 0;
    rst                   = 1'b1;
    rst2                  = 1'b1;
    bus.stall_i           = 1'b0;
    bus.flush_i           = 1'b0;
    bus.redirect_valid_i  = 1'b0;
    bus.redirect_pc_i     = 32'h0;
    bus2.stall_i          = 1'b0;
    bus2.flush_i          = 1'b0;
    bus2.redirect_valid_i = 1'b0;
    bus2.redirect_pc_i    = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_redirect_stall();
    test_misalign();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
